// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and constants for the sram request arbiter.
// Owner encoding, lock states, sram size codes and the request bundle.
package sram_req_arbiter_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_INST = 2'd1,
        LK_DATA = 2'd2
    } lock_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_id_queue.sv
// In-order owner queue: one bit per accepted request (1 = data side).
// Circular buffer with natural pointer wrap and an occupancy count.
module sram_id_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             push_own,
    input  logic             pop,
    output logic             head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rp];
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // Storage, pointers and occupancy; push+pop together keeps count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem   <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                mem[wp] <= push_own;
                wp      <= wp + PTR_W'(1);
            end
            if (pop_ok) begin
                rp <= rp + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between fetch and data requesters.
// Data has priority; a presented request stays locked until accepted.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        err_unexp
);

    lock_e            lock_q;
    lock_e            lock_d;
    sram_req_t        inst_r;
    sram_req_t        data_r;
    sram_req_t        sel_r;
    logic             sel_vld;
    logic             sel_own;
    logic             grant;
    logic             push;
    logic             pop;
    logic             q_head;
    logic             q_empty;
    logic             q_full;
    logic [CNT_W-1:0] q_cnt;

    assign inst_r = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                      addr: inst_addr, wdata: inst_wdata};
    assign data_r = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                      addr: data_addr, wdata: data_wdata};

    // Pick the owner of the address phase and the next lock state.
    always_comb begin
        sel_vld = 1'b0;
        sel_own = OWN_INST;
        lock_d  = lock_q;
        unique case (lock_q)
            LK_INST: begin
                sel_vld = 1'b1;
                sel_own = OWN_INST;
            end
            LK_DATA: begin
                sel_vld = 1'b1;
                sel_own = OWN_DATA;
            end
            default: begin
                if (!q_full) begin
                    if (data_req) begin
                        sel_vld = 1'b1;
                        sel_own = OWN_DATA;
                    end else if (inst_req) begin
                        sel_vld = 1'b1;
                        sel_own = OWN_INST;
                    end
                end
            end
        endcase
        if (sel_vld) begin
            if (bus_addr_ok) begin
                lock_d = LK_NONE;
            end else if (sel_own == OWN_DATA) begin
                lock_d = LK_DATA;
            end else begin
                lock_d = LK_INST;
            end
        end
    end

    // Lock register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q <= LK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Reset masks the combinational request path so the bus drops at once.
    assign grant = sel_vld & resetn;
    assign sel_r = (sel_own == OWN_DATA) ? data_r : inst_r;

    assign bus_req   = grant;
    assign bus_wr    = grant ? sel_r.wr    : 1'b0;
    assign bus_size  = grant ? sel_r.size  : 2'd0;
    assign bus_wstrb = grant ? sel_r.wstrb : 4'd0;
    assign bus_addr  = grant ? sel_r.addr  : 32'd0;
    assign bus_wdata = grant ? sel_r.wdata : 32'd0;

    assign inst_addr_ok = grant & bus_addr_ok & (sel_own == OWN_INST);
    assign data_addr_ok = grant & bus_addr_ok & (sel_own == OWN_DATA);

    assign push = grant & bus_addr_ok;
    assign pop  = bus_data_ok & ~q_empty;

    assign inst_data_ok = pop & (q_head == OWN_INST);
    assign data_data_ok = pop & (q_head == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;

    sram_id_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_idq (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_own (sel_own),
        .pop      (pop),
        .head     (q_head),
        .empty    (q_empty),
        .full     (q_full),
        .count    (q_cnt)
    );

    // Sticky flag for a return with no outstanding request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_unexp <= 1'b0;
        end else if (bus_data_ok && q_empty) begin
            err_unexp <= 1'b1;
        end
    end

    a_cnt_bound: assert property (
        @(posedge clk) disable iff (!resetn) q_cnt <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized and directed bench for sram_req_arbiter.
// Reference model: owner queue plus pending-lock owner, from the rules.
module tb_sram_req_arbiter;
    import sram_req_arbiter_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [3:0]  inst_wstrb = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [3:0]  data_wstrb = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 0, bus_data_ok = 0;
    logic [31:0] bus_rdata = 0;
    logic        err_unexp;

    always #5 clk = ~clk;

    sram_req_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .err_unexp(err_unexp)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // model state
    int q[$];
    int pend = -1;
    bit m_err = 0;
    int m_sel;
    bit m_pop, m_aok, m_unexp;
    logic        obs_breq, obs_iaok, obs_daok, obs_idok, obs_ddok;
    logic [31:0] obs_addr;

    task automatic model_check();
        int sel;
        int own;
        logic [31:0] e_addr, e_wdata, e_ctl;
        sel = -1;
        if (pend >= 0) sel = pend;
        else if (q.size() < DEPTH) sel = data_req ? 1 : (inst_req ? 0 : -1);
        e_addr = 0; e_wdata = 0; e_ctl = 0;
        if (sel == 1) begin
            e_addr = data_addr; e_wdata = data_wdata;
            e_ctl = 32'({data_wr, data_size, data_wstrb});
        end else if (sel == 0) begin
            e_addr = inst_addr; e_wdata = inst_wdata;
            e_ctl = 32'({inst_wr, inst_size, inst_wstrb});
        end
        m_pop = bus_data_ok && q.size() > 0;
        m_unexp = bus_data_ok && q.size() == 0;
        own = m_pop ? q[0] : -1;
        chk("bus_req", 32'(bus_req), 32'(sel >= 0));
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_wdata", bus_wdata, e_wdata);
        chk("bus_ctl", 32'({bus_wr, bus_size, bus_wstrb}), e_ctl);
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(bus_addr_ok && sel == 0));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(bus_addr_ok && sel == 1));
        chk("inst_data_ok", 32'(inst_data_ok), 32'(own == 0));
        chk("data_data_ok", 32'(data_data_ok), 32'(own == 1));
        chk("inst_rdata", inst_rdata, own == 0 ? bus_rdata : 32'd0);
        chk("data_rdata", data_rdata, own == 1 ? bus_rdata : 32'd0);
        chk("err_unexp", 32'(err_unexp), 32'(m_err));
        m_sel = sel;
        m_aok = bus_addr_ok;
        obs_breq = bus_req; obs_addr = bus_addr;
        obs_iaok = inst_addr_ok; obs_daok = data_addr_ok;
        obs_idok = inst_data_ok; obs_ddok = data_data_ok;
    endtask

    task automatic model_update();
        if (m_pop) void'(q.pop_front());
        if (m_unexp) m_err = 1;
        if (m_sel >= 0) begin
            if (m_aok) begin
                q.push_back(m_sel);
                pend = -1;
            end else begin
                pend = m_sel;
            end
        end
    endtask

    task automatic drive(input bit ir, input logic [31:0] ia,
                         input bit dr, input logic [31:0] da,
                         input bit aok, input bit dok,
                         input logic [31:0] rd);
        inst_req = ir; inst_addr = ia; inst_wdata = ia ^ 32'hffff0000;
        inst_wr = 0; inst_size = SIZE_WORD; inst_wstrb = 4'hf;
        data_req = dr; data_addr = da; data_wdata = da ^ 32'h5a5a5a5a;
        data_wr = da[2]; data_size = da[1:0]; data_wstrb = da[7:4];
        bus_addr_ok = aok; bus_data_ok = dok; bus_rdata = rd;
    endtask

    task automatic cyc(input bit ir, input logic [31:0] ia,
                       input bit dr, input logic [31:0] da,
                       input bit aok, input bit dok,
                       input logic [31:0] rd);
        @(negedge clk);
        drive(ir, ia, dr, da, aok, dok, rd);
        #1 model_check();
        @(posedge clk);
        model_update();
    endtask

    task automatic drain();
        for (int k = 0; k < 3 * DEPTH; k++) begin
            if (q.size() == 0) break;
            cyc(0, 0, 0, 0, 0, 1, $urandom);
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    localparam logic [31:0] IA = 32'h1c000000;
    localparam logic [31:0] DA = 32'h00001004;

    initial begin
        bit ih, dh;
        logic [31:0] ia, da;

        // reset state, with requests and acks active
        drive(0, 0, 1, DA, 1, 1, 32'h1234);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_daok", 32'(data_addr_ok), 0);
        chk("rst_ddok", 32'(data_data_ok), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_err", 32'(err_unexp), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        resetn = 1;

        // both request together: data first, then inst
        cyc(1, IA, 1, DA, 1, 0, 0);
        chk("t1_data_first", 32'(obs_daok), 1);
        chk("t1_inst_wait", 32'(obs_iaok), 0);
        cyc(1, IA, 0, 0, 1, 0, 0);
        chk("t1_inst_next", 32'(obs_iaok), 1);
        cyc(0, 0, 0, 0, 0, 1, 32'hdeadbeef);
        chk("t1_ret_data", 32'(obs_ddok), 1);
        cyc(0, 0, 0, 0, 0, 1, 32'h12345678);
        chk("t1_ret_inst", 32'(obs_idok), 1);

        // lock hold: inst stalled, data arrives meanwhile
        cyc(1, IA, 0, 0, 0, 0, 0);
        chk("lock_c0", obs_addr, IA);
        cyc(1, IA, 1, DA, 0, 0, 0);
        chk("lock_c1", obs_addr, IA);
        cyc(1, IA, 1, DA, 0, 0, 0);
        chk("lock_c2", obs_addr, IA);
        cyc(1, IA, 1, DA, 1, 0, 0);
        chk("lock_inst_ok", 32'(obs_iaok), 1);
        cyc(0, 0, 1, DA, 1, 0, 0);
        chk("lock_data_ok", 32'(obs_daok), 1);
        drain();

        // fill the queue with mixed owners
        cyc(0, 0, 1, 32'h2000, 1, 0, 0);
        cyc(1, 32'h1c000010, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 32'h2004, 1, 0, 0);
        cyc(1, 32'h1c000014, 0, 0, 1, 0, 0);
        cyc(1, 32'h1c000018, 0, 0, 1, 0, 0);
        chk("full_no_req", 32'(obs_breq), 0);
        cyc(1, 32'h1c000018, 0, 0, 1, 1, 32'haaaa0001);
        chk("full_pop_req", 32'(obs_breq), 0);
        chk("full_pop_data", 32'(obs_ddok), 1);
        cyc(1, 32'h1c000018, 0, 0, 1, 0, 0);
        chk("full_regrant", 32'(obs_breq), 1);
        cyc(0, 0, 1, 32'h2008, 1, 1, 32'haaaa0002);
        chk("full2_no_req", 32'(obs_breq), 0);
        cyc(0, 0, 1, 32'h2008, 1, 1, 32'haaaa0003);
        chk("pushpop_grant", 32'(obs_daok), 1);
        chk("pushpop_ret", 32'(obs_ddok), 1);
        drain();

        // unexpected return with empty queue
        cyc(0, 0, 0, 0, 0, 1, 32'h55555555);
        chk("unexp_iok", 32'(obs_idok), 0);
        chk("unexp_dok", 32'(obs_ddok), 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("unexp_sticky", 32'(err_unexp), 1);

        // randomized traffic with holding requesters
        ih = 0; dh = 0; ia = 0; da = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!ih && $urandom_range(0, 2) == 0) begin
                ih = 1; ia = $urandom & 32'hfffffffc;
            end
            if (!dh && $urandom_range(0, 2) == 0) begin
                dh = 1; da = $urandom;
            end
            cyc(ih, ia, dh, da, $urandom_range(0, 9) < 6,
                q.size() > 0 && $urandom_range(0, 9) < 3, $urandom);
            if (m_sel == 0 && m_aok) ih = 0;
            if (m_sel == 1 && m_aok) dh = 0;
        end
        for (int k = 0; k < 20 && (ih || dh); k++) begin
            cyc(ih, ia, dh, da, 1, 0, 0);
            if (m_sel == 0 && m_aok) ih = 0;
            if (m_sel == 1 && m_aok) dh = 0;
        end
        chk("rand_idle", 32'({ih, dh}), 0);
        drain();

        // async reset with two outstanding and data locked
        cyc(1, 32'h100, 0, 0, 1, 0, 0);
        cyc(1, 32'h104, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 32'h3000, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h3000, 1, 1, 32'h77777777);
        #1;
        chk("prerst_req", 32'(bus_req), 1);
        chk("prerst_daok", 32'(data_addr_ok), 1);
        chk("prerst_idok", 32'(inst_data_ok), 1);
        #1 resetn = 0;
        #1;
        chk("mrst_req", 32'(bus_req), 0);
        chk("mrst_daok", 32'(data_addr_ok), 0);
        chk("mrst_iaok", 32'(inst_addr_ok), 0);
        chk("mrst_idok", 32'(inst_data_ok), 0);
        chk("mrst_ddok", 32'(data_data_ok), 0);
        chk("mrst_err", 32'(err_unexp), 0);
        q.delete(); pend = -1; m_err = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1;
        cyc(1, IA, 0, 0, 1, 0, 0);
        chk("post_rst_grant", 32'(obs_iaok), 1);
        cyc(0, 0, 0, 0, 0, 1, 32'h0badf00d);
        chk("post_rst_ret", 32'(obs_idok), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
